// File: rtl/spin_sweep_ctrl.sv
// spin_sweep_ctrl
//   Sequencer for the column dot-product engine of the Ising solver.
//   Walks the J matrix one column at a time: reads the column, starts the
//   engine, waits for its result, then updates one spin in place
//   (Gauss-Seidel order). Full sweeps repeat until a sweep produces no flip
//   or the sweep limit is reached.
//
//   Optional build macro: SPIN_SWEEP_TIMEOUT_EN
//     Adds a per-column watchdog (TIMEOUT cycles in WAIT) and the
//     timeout_err output. Left undefined, WAIT waits indefinitely.
//
//   Ports
//     clk, rst        clock, synchronous active-high reset
//     start           begin solve (accepted only when idle)
//     max_sweeps_i    sweep limit, latched at start (0 behaves as 1)
//     e_p_i           energy threshold, latched at start
//     sigma_init_i    initial spins, latched at start (1 = +1)
//     jmem_rd_en      J column read strobe
//     jmem_addr       column index
//     mm_start        one-cycle engine start
//     mm_e_p          latched threshold to the engine
//     mm_sigma        current spin vector to the engine
//     mm_dot_result   signed engine result
//     mm_done         engine completion (only observed in WAIT)
//     mm_flag         engine threshold flag
//     busy            solve in progress (through DONE)
//     done            one-cycle completion pulse
//     converged       last sweep had no flips
//     sweep_cnt       sweeps completed
//     flip_cnt        flips in current/last sweep
//     timeout_err     watchdog expired (only with SPIN_SWEEP_TIMEOUT_EN)
module spin_sweep_ctrl #(
  parameter int VECTOR_WIDTH = 256,
  parameter int N            = 8,
  parameter int ACC_WIDTH    = N + 2*$clog2(VECTOR_WIDTH),
  parameter int SWEEP_W      = 16
`ifdef SPIN_SWEEP_TIMEOUT_EN
  , parameter int TIMEOUT    = 4*VECTOR_WIDTH*VECTOR_WIDTH
`endif
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [SWEEP_W-1:0]              max_sweeps_i,
  input  logic [ACC_WIDTH:0]              e_p_i,
  input  logic [VECTOR_WIDTH-1:0]         sigma_init_i,
  output logic                            jmem_rd_en,
  output logic [$clog2(VECTOR_WIDTH)-1:0] jmem_addr,
  output logic                            mm_start,
  output logic [ACC_WIDTH:0]              mm_e_p,
  output logic [VECTOR_WIDTH-1:0]         mm_sigma,
  input  logic signed [ACC_WIDTH:0]       mm_dot_result,
  input  logic                            mm_done,
  input  logic                            mm_flag,
  output logic                            busy,
  output logic                            done,
  output logic                            converged,
  output logic [SWEEP_W-1:0]              sweep_cnt,
`ifdef SPIN_SWEEP_TIMEOUT_EN
  output logic                            timeout_err,
`endif
  output logic [$clog2(VECTOR_WIDTH):0]   flip_cnt
);

  localparam int AW = $clog2(VECTOR_WIDTH);
  localparam logic [AW-1:0] LAST_COL = AW'(VECTOR_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_COL, S_START, S_WAIT, S_UPDATE, S_SWEEP_END, S_DONE
  } state_t;

  state_t                   r_state, w_next;
  logic [AW-1:0]            r_col;
  logic [VECTOR_WIDTH-1:0]  r_sigma;
  logic [ACC_WIDTH:0]       r_e_p;
  logic [SWEEP_W-1:0]       r_max;
  logic [SWEEP_W-1:0]       r_sweep;
  logic [AW:0]              r_flip;
  logic                     r_conv;
  logic signed [ACC_WIDTH:0] r_h;
  logic                     r_flag;
  logic [SWEEP_W-1:0]       w_sweep_inc;
  logic                     w_old, w_new;
  logic                     w_timeout;

`ifdef SPIN_SWEEP_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] r_wdog;
  logic           r_terr;
  assign w_timeout   = (r_wdog == WDW'(TIMEOUT - 1));
  assign timeout_err = r_terr;
`else
  assign w_timeout   = 1'b0;
`endif

  assign w_sweep_inc = r_sweep + 1'b1;
  assign w_old       = r_sigma[r_col];

  // Flag wins; otherwise sign of h decides, and h == 0 keeps the old spin.
  always_comb begin
    w_new = w_old;
    if (r_flag)              w_new = 1'b1;
    else if (r_h != '0)      w_new = ~r_h[ACC_WIDTH];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (start) w_next = S_RD_COL;
      S_RD_COL:    w_next = S_START;
      S_START:     w_next = S_WAIT;
      S_WAIT: begin
        if (mm_done)        w_next = S_UPDATE;
        else if (w_timeout) w_next = S_DONE;
      end
      S_UPDATE:    w_next = (r_col == LAST_COL) ? S_SWEEP_END : S_RD_COL;
      S_SWEEP_END: w_next = ((r_flip == '0) || (w_sweep_inc == r_max)) ? S_DONE : S_RD_COL;
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_sigma <= '0;
      r_e_p   <= '0;
      r_max   <= '0;
      r_sweep <= '0;
      r_flip  <= '0;
      r_conv  <= 1'b0;
      r_h     <= '0;
      r_flag  <= 1'b0;
`ifdef SPIN_SWEEP_TIMEOUT_EN
      r_wdog  <= '0;
      r_terr  <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (start) begin
          r_max   <= (max_sweeps_i == '0) ? SWEEP_W'(1) : max_sweeps_i;
          r_e_p   <= e_p_i;
          r_sigma <= sigma_init_i;
          r_col   <= '0;
          r_sweep <= '0;
          r_flip  <= '0;
          r_conv  <= 1'b0;
`ifdef SPIN_SWEEP_TIMEOUT_EN
          r_terr  <= 1'b0;
`endif
        end
`ifdef SPIN_SWEEP_TIMEOUT_EN
        S_START: r_wdog <= '0;
`endif
        S_WAIT: begin
          if (mm_done) begin
            r_h    <= mm_dot_result;
            r_flag <= mm_flag;
          end
`ifdef SPIN_SWEEP_TIMEOUT_EN
          else if (w_timeout) r_terr <= 1'b1;
          else                r_wdog <= r_wdog + 1'b1;
`endif
        end
        S_UPDATE: begin
          r_sigma[r_col] <= w_new;
          if (w_new != w_old)    r_flip <= r_flip + 1'b1;
          if (r_col != LAST_COL) r_col  <= r_col + 1'b1;
        end
        S_SWEEP_END: begin
          r_sweep <= w_sweep_inc;
          if (r_flip == '0) begin
            r_conv <= 1'b1;
          end else if (w_sweep_inc != r_max) begin
            r_col  <= '0;
            r_flip <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign jmem_rd_en = (r_state == S_RD_COL);
  assign jmem_addr  = r_col;
  assign mm_start   = (r_state == S_START);
  assign mm_e_p     = r_e_p;
  assign mm_sigma   = r_sigma;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign converged  = r_conv;
  assign sweep_cnt  = r_sweep;
  assign flip_cnt   = r_flip;

endmodule

// File: tb/tb_spin_sweep_ctrl.sv
module tb_spin_sweep_ctrl;

  localparam int VW   = 4;
  localparam int ACCW = 12;   // 8 + 2*clog2(4)
  localparam int LAT  = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [15:0]            max_sweeps_i;
  logic [ACCW:0]          e_p_i;
  logic [VW-1:0]          sigma_init_i;
  logic                   jmem_rd_en;
  logic [1:0]             jmem_addr;
  logic                   mm_start;
  logic [ACCW:0]          mm_e_p;
  logic [VW-1:0]          mm_sigma;
  logic signed [ACCW:0]   mm_dot_result;
  logic                   mm_done;
  logic                   mm_flag;
  logic                   busy, done, converged;
  logic [15:0]            sweep_cnt;
  logic [2:0]             flip_cnt;
`ifdef SPIN_SWEEP_TIMEOUT_EN
  logic                   timeout_err;
`endif

  always #5 clk = ~clk;

  spin_sweep_ctrl #(
    .VECTOR_WIDTH(VW),
    .N(8),
    .SWEEP_W(16)
`ifdef SPIN_SWEEP_TIMEOUT_EN
    , .TIMEOUT(10)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .max_sweeps_i(max_sweeps_i), .e_p_i(e_p_i), .sigma_init_i(sigma_init_i),
    .jmem_rd_en(jmem_rd_en), .jmem_addr(jmem_addr), .mm_start(mm_start),
    .mm_e_p(mm_e_p), .mm_sigma(mm_sigma), .mm_dot_result(mm_dot_result),
    .mm_done(mm_done), .mm_flag(mm_flag), .busy(busy), .done(done),
    .converged(converged), .sweep_cnt(sweep_cnt),
`ifdef SPIN_SWEEP_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .flip_cnt(flip_cnt)
  );

  // ---------------- engine model ----------------
  int unsigned       g_mode = 0;
  logic              g_hang = 1'b0;
  logic              r_stray = 1'b0;
  logic              r_mdone;
  int unsigned       cnt;
  int unsigned       n_starts;
  int unsigned       m_col;
  logic signed [ACCW:0] m_h;
  logic              m_f;

  assign mm_done = r_mdone | r_stray;

  always @(posedge clk) begin
    r_mdone <= 1'b0;
    if (rst) begin
      cnt <= 0;
    end else begin
      if (start && !busy) n_starts <= 0;
      if (mm_start) begin
        m_col = jmem_addr;
        m_f   = 1'b0;
        case (g_mode)
          1:       m_h = ((n_starts / VW) % 2 == 0) ? 13'sd5 : -13'sd5;
          2:       m_h = 13'sd0;
          3:       begin m_h = -13'sd7; m_f = 1'b1; end
          4:       m_h = -13'sd1;
          6:       case (m_col)
                     0: m_h = 13'sd3;
                     1: m_h = -13'sd2;
                     2: m_h = 13'sd0;
                     default: m_h = -13'sd1;
                   endcase
          7:       m_h = (m_col == 0) ? 13'sd5 : (mm_sigma[m_col-1] ? 13'sd2 : -13'sd2);
          default: m_h = 13'sd5;
        endcase
        mm_dot_result <= m_h;
        mm_flag       <= m_f;
        n_starts      <= n_starts + 1;
        cnt           <= LAT;
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1 && !g_hang) r_mdone <= 1'b1;
      end
    end
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic start_pulse(input logic [3:0] sig, input logic [15:0] maxs);
    @(negedge clk);
    start = 1'b1; sigma_init_i = sig; max_sweeps_i = maxs; e_p_i = 13'h0123;
    @(negedge clk);
    // scramble inputs after acceptance; the latched copies must hold
    start = 1'b0; sigma_init_i = ~sig; max_sweeps_i = 16'd7; e_p_i = 13'h1abc;
  endtask

  task automatic wait_done(output logic got, output logic [2:0] peak, output int unsigned cyc);
    got = 1'b0; peak = '0; cyc = 1;
    while (!got && cyc < 2000) begin
      if (sweep_cnt == 0 && flip_cnt > peak) peak = flip_cnt;
      if (done) got = 1'b1;
      else begin @(negedge clk); cyc++; end
    end
  endtask

  typedef struct {
    int unsigned mode;
    logic [3:0]  sig;
    logic [15:0] maxs;
    logic [15:0] e_sweep;
    logic        e_conv;
    logic [3:0]  e_sigma;
    logic [2:0]  e_flip;
    logic [2:0]  e_peak;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic got;
    logic [2:0] pk;
    int unsigned cyc;
    int unsigned guard;

    vecs[0] = '{0, 4'b0000, 16'd10, 16'd2, 1'b1, 4'b1111, 3'd0, 3'd4}; // all +5
    vecs[1] = '{1, 4'b0000, 16'd3,  16'd3, 1'b0, 4'b1111, 3'd4, 3'd4}; // alternating sign
    vecs[2] = '{2, 4'b1010, 16'd5,  16'd1, 1'b1, 4'b1010, 3'd0, 3'd0}; // h = 0 keeps spins
    vecs[3] = '{3, 4'b0000, 16'd5,  16'd2, 1'b1, 4'b1111, 3'd0, 3'd4}; // flag beats h=-7
    vecs[4] = '{4, 4'b1111, 16'd5,  16'd2, 1'b1, 4'b0000, 3'd0, 3'd4}; // h = -1
    vecs[5] = '{5, 4'b0000, 16'd0,  16'd1, 1'b0, 4'b1111, 3'd4, 3'd4}; // max 0 acts as 1
    vecs[6] = '{6, 4'b0110, 16'd5,  16'd2, 1'b1, 4'b0101, 3'd0, 3'd2}; // mixed per column
    vecs[7] = '{7, 4'b0000, 16'd5,  16'd2, 1'b1, 4'b1111, 3'd0, 3'd4}; // in-place chaining

    rst = 1'b1; start = 1'b0; max_sweeps_i = '0; e_p_i = '0; sigma_init_i = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_rd_en", jmem_rd_en, 0);
    check("rst_start", mm_start, 0);
    check("rst_addr",  jmem_addr, 0);
    check("rst_sigma", mm_sigma, 0);
    check("rst_ep",    mm_e_p, 0);
    check("rst_sweep", sweep_cnt, 0);
    check("rst_flip",  flip_cnt, 0);
    check("rst_conv",  converged, 0);
`ifdef SPIN_SWEEP_TIMEOUT_EN
    check("rst_terr",  timeout_err, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // stray engine completion while idle must not start anything
    r_stray = 1'b1; @(negedge clk); r_stray = 1'b0; @(negedge clk);
    check("stray_idle_busy", busy, 0);

    for (int i = 0; i < 8; i++) begin
      g_mode = vecs[i].mode;
      start_pulse(vecs[i].sig, vecs[i].maxs);
      wait_done(got, pk, cyc);
      check($sformatf("v%0d_done", i),  got, 1);
      check($sformatf("v%0d_sweep", i), sweep_cnt, vecs[i].e_sweep);
      check($sformatf("v%0d_conv", i),  converged, vecs[i].e_conv);
      check($sformatf("v%0d_sigma", i), mm_sigma, vecs[i].e_sigma);
      check($sformatf("v%0d_flip", i),  flip_cnt, vecs[i].e_flip);
      check($sformatf("v%0d_peak", i),  pk, vecs[i].e_peak);
      check($sformatf("v%0d_ep", i),    mm_e_p, 13'h0123);
      @(negedge clk);
      check($sformatf("v%0d_idle", i),  busy, 0);
      check($sformatf("v%0d_hold", i),  sweep_cnt, vecs[i].e_sweep);
    end

    // reset while waiting on column 2
    g_mode = 0;
    start_pulse(4'b0000, 16'd10);
    guard = 0;
    while (!(n_starts == 3 && !mm_start) && guard < 200) begin
      @(negedge clk); guard++;
    end
    check("rstmid_reach_col2", jmem_addr, 2);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_busy",  busy, 0);
    check("rstmid_done",  done, 0);
    check("rstmid_start", mm_start, 0);
    check("rstmid_rd",    jmem_rd_en, 0);
    check("rstmid_sigma", mm_sigma, 0);
    check("rstmid_flip",  flip_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_start2", mm_start, 0);

    // restart from col 0; a start while busy is ignored
    start_pulse(4'b0000, 16'd10);
    check("restart_rd",   jmem_rd_en, 1);
    check("restart_addr", jmem_addr, 0);
    repeat (4) @(negedge clk);
    start = 1'b1; sigma_init_i = 4'b1111; max_sweeps_i = 16'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(got, pk, cyc);
    check("restart_done",  got, 1);
    check("restart_sweep", sweep_cnt, 2);
    check("restart_conv",  converged, 1);
    check("restart_sigma", mm_sigma, 4'b1111);
    // start coincident with done is ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_at_done_busy", busy, 0);
    @(negedge clk);
    check("start_at_done_idle", busy, 0);

`ifdef SPIN_SWEEP_TIMEOUT_EN
    g_hang = 1'b1;
    start_pulse(4'b0000, 16'd5);
    wait_done(got, pk, cyc);
    check("to_done",   got, 1);
    check("to_cycles", cyc, 13);
    check("to_err",    timeout_err, 1);
    check("to_conv",   converged, 0);
    g_hang = 1'b0;
    @(negedge clk);
    check("to_sticky", timeout_err, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spin_sweep_ctrl.md
Name: spin_sweep_ctrl

Overview:
- Initiator/sequencer for the column dot-product engine in the Ising solver datapath.
- Walks the J matrix column by column:
  - addresses J memory;
  - pulses the engine start;
  - waits for engine done;
  - uses the signed result and the threshold flag to update one spin.
- Repeats full sweeps until no spin flips or a sweep limit is hit, then returns the final spin vector.

Parameters:
- VECTOR_WIDTH, 256: number of spins / J column length.
- N, 8: J element width (passes through to engine sizing only).
- ACC_WIDTH, N+2*$clog2(VECTOR_WIDTH): engine accumulator width; dot result and threshold are ACC_WIDTH+1 bits.
- SWEEP_W, 16: width of sweep limit and sweep counter.
- TIMEOUT, 4*VECTOR_WIDTH*VECTOR_WIDTH: watchdog limit in cycles per column (only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin solve; accepted only in IDLE.
- max_sweeps_i  in  SWEEP_W  sweep limit, latched at start; 0 is treated as 1.
- e_p_i  in  ACC_WIDTH+1  positive-energy threshold, latched at start.
- sigma_init_i  in  VECTOR_WIDTH  initial spins, latched at start; bit i=1 means +1.
- jmem_rd_en  out  1  J column read strobe.
- jmem_addr  out  $clog2(VECTOR_WIDTH)  column index; held stable from read until UPDATE.
- mm_start  out  1  one-cycle start pulse to the engine.
- mm_e_p  out  ACC_WIDTH+1  latched threshold to the engine.
- mm_sigma  out  VECTOR_WIDTH  current spin vector to the engine.
- mm_dot_result  in  ACC_WIDTH+1 signed  engine result.
- mm_done  in  1  engine completion.
- mm_flag  in  1  engine threshold flag (result > E_p).
- busy  out  1  high from start acceptance through the DONE state.
- done  out  1  one-cycle completion pulse.
- converged  out  1  last sweep had zero flips; valid with done, held until next start.
- sweep_cnt  out  SWEEP_W  sweeps completed; held until next start.
- flip_cnt  out  $clog2(VECTOR_WIDTH)+1  flips in the current/last sweep.

Behaviour:
- Reset values: all outputs 0, state IDLE, internal sigma 0.
- States and transitions:
  - IDLE: on start, latch inputs, col=0, sweep_cnt=0, flip_cnt=0, converged=0 -> RD_COL.
  - RD_COL: jmem_rd_en=1, jmem_addr=col for one cycle -> START. Memory read latency is 1 cycle; data is valid at the engine input in START.
  - START: mm_start=1 for exactly one cycle -> WAIT.
  - WAIT: sample mm_done only here; on mm_done=1 register mm_dot_result and mm_flag -> UPDATE.
  - UPDATE (one cycle), with h = registered result and old = sigma[col]:
    - new = 1 if flag;
    - else 1 if h>0;
    - else 0 if h<0;
    - else old (h=0 leaves the spin unchanged).
    - Write sigma[col]=new. If new!=old, flip_cnt++.
    - If col==VECTOR_WIDTH-1 -> SWEEP_END; else col++ -> RD_COL.
  - SWEEP_END: sweep_cnt++.
    - If flip_cnt==0: converged=1 -> DONE.
    - Else if incremented sweep_cnt==max_sweeps: -> DONE.
    - Else col=0, flip_cnt=0 -> RD_COL.
  - DONE: done=1 for one cycle -> IDLE.
- Signed arithmetic: h is compared as signed ACC_WIDTH+1 bits; h=-1 (all ones) flips to 0.
- mm_sigma reflects updates made earlier in the same sweep (in-place, Gauss-Seidel order).
- start asserted while busy is ignored. start in the same cycle as done is ignored; IDLE is reached the cycle after.
- rst mid-solve returns to IDLE in one cycle with all outputs 0. mm_start is never asserted the cycle after rst.
- mm_done seen outside WAIT is ignored.
- Minimum per-column cost: 4 cycles plus engine latency.

Optional Feature:
- Macro: SPIN_SWEEP_TIMEOUT_EN.
- Defined: a watchdog counter clears on entering WAIT and increments each WAIT cycle. Reaching TIMEOUT forces DONE, asserts an extra output port timeout_err (1 bit, sticky until next start), and leaves converged=0.
- Undefined: no counter, no timeout_err port; WAIT waits indefinitely.

Test Plan:
- VECTOR_WIDTH=4, engine model returns h=+5 for every column, sigma_init=4'b0000:
  - sweep 1 flips all four spins (flip_cnt=4);
  - sweep 2 has 0 flips;
  - done with converged=1, sweep_cnt=2, mm_sigma=4'b1111.
- Model alternates h sign every sweep, max_sweeps=3: done after sweep_cnt=3, converged=0.
- h=0 on every column, sigma_init=4'b1010: one sweep, flip_cnt=0, sigma unchanged 4'b1010, converged=1.
- mm_flag=1 with h=-7: spin forced to 1. h=-1 (all-ones) without flag: spin becomes 0.
- Assert rst during WAIT of column 2:
  - next cycle IDLE, busy=0, done=0, mm_start=0;
  - a new start runs cleanly from col 0.
- SPIN_SWEEP_TIMEOUT_EN defined, TIMEOUT=10, model never raises mm_done: done after 10 WAIT cycles with timeout_err=1, converged=0.
